// File: rtl/crc_stream_appender_if.sv
// Byte-stream bundle for crc_stream_appender: input payload side, output side and busy status.
interface crc_stream_appender_if;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       s_last_i;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       busy_o;

  // slave: the appender itself; master: whoever feeds it and drains it
  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o, busy_o
  );
  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o, busy_o
  );
endinterface

// File: rtl/crc_stream_appender.sv
// Passes payload bytes through with one cycle of latency and appends a
// parametrised CRC trailer after the last byte of every frame.
module crc_stream_appender #(
  parameter logic [63:0] POLY      = 64'h04C11DB7,
  parameter int unsigned CRC_SIZE  = 32,
  parameter logic [63:0] INIT      = 64'hFFFFFFFF,
  parameter bit          REF_IN    = 1'b1,
  parameter bit          REF_OUT   = 1'b1,
  parameter logic [63:0] XOR_OUT   = 64'hFFFFFFFF,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  crc_stream_appender_if.slave bus
);

  localparam int unsigned CW    = CRC_SIZE;
  localparam int unsigned N     = CRC_SIZE / 8;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]    POLY_W   = POLY[CW-1:0];
  localparam logic [CW-1:0]    INIT_W   = INIT[CW-1:0];
  localparam logic [CW-1:0]    XOR_W    = XOR_OUT[CW-1:0];
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic {PASS, APPEND} state_t;

  state_t           state;
  logic [CW-1:0]    crc;
  logic [CW-1:0]    trail;
  logic [IDX_W-1:0] idx;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_last;
  logic             busy;

  logic             load_ok;
  logic             s_ready;
  logic             accept;
  logic [CW-1:0]    crc_next;
  logic [CW-1:0]    crc_final;
  logic [IDX_W-1:0] sel_idx;
  logic [7:0]       trail_byte;

  // Eight serial LFSR steps unrolled so a whole byte is absorbed per cycle
  function automatic logic [CW-1:0] crc_byte(input logic [CW-1:0] c, input logic [7:0] d);
    logic [CW-1:0] r;
    logic          b;
    logic          fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      b  = REF_IN ? d[i] : d[7-i];
      fb = r[CW-1] ^ b;
      r  = {r[CW-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    for (int i = 0; i < int'(CW); i++) r[i] = c[CW-1-i];
    return r;
  endfunction

  assign load_ok   = !m_valid || bus.m_ready_i;
  assign s_ready   = (state == PASS) && load_ok;
  assign accept    = bus.s_valid_i && s_ready;
  assign crc_next  = crc_byte(crc, bus.s_data_i);
  assign crc_final = (REF_OUT ? bitrev(crc_next) : crc_next) ^ XOR_W;
  assign sel_idx   = LSB_FIRST ? idx : (IDX_LAST - idx);

  // Constant-slice mux keeps the trailer byte select free of dynamic indexing
  always_comb begin
    trail_byte = 8'h00;
    for (int k = 0; k < int'(N); k++) begin
      if (sel_idx == IDX_W'(k)) trail_byte = trail[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= PASS;
      crc     <= INIT_W;
      trail   <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (accept) begin
            m_data  <= bus.s_data_i;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_next;
            if (bus.s_last_i) begin
              trail <= crc_final;
              idx   <= '0;
              state <= APPEND;
              busy  <= 1'b1;
            end
          end else if (bus.m_ready_i) begin
            m_valid <= 1'b0;
          end
        end
        APPEND: begin
          if (load_ok) begin
            m_data  <= trail_byte;
            m_valid <= 1'b1;
            m_last  <= (idx == IDX_LAST);
            if (idx == IDX_LAST) begin
              crc   <= INIT_W;
              idx   <= '0;
              state <= PASS;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = m_data;
  assign bus.m_last_o  = m_last;
  assign bus.busy_o    = busy;

endmodule
